// File: rtl/display_reader_if.sv
// Read-side handshake of the clock-crossing word buffer.
// The buffer (master) presents a word with a valid flag; the reader
// (slave) pops it with a one-cycle ack strobe.
interface display_reader_if;
  logic        data_2_valid;
  logic [15:0] data_2;
  logic        data_2_ack;

  modport master (
    output data_2_valid,
    output data_2,
    input  data_2_ack
  );

  modport slave (
    input  data_2_valid,
    input  data_2,
    output data_2_ack
  );
endinterface

// File: rtl/display_reader.sv
// display_reader: pops 16-bit words from the buffer read port, converts each
// to five BCD digits with a sequential double-dabble (16 cycles), then holds
// the result on an 8-digit multiplexed seven-segment display for HOLD_CYCLES
// before popping the next word.
// Digit map: an[7] source ('F'/'t'), an[6] live program number, an[5] blank,
// an[4:0] ten-thousands .. units.
// Optional feature: define DISP_ZERO_BLANK_EN to blank leading zeros in
// an[4:1]; the units digit always shows.
module display_reader #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter logic [31:0] HOLD_CYCLES = 32'd25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  display_reader_if.slave         rd,
  input  logic                    modules,
  input  logic [2:0]              prog,
  output logic                    busy,
  output logic                    parity,
  output logic [7:0]              an,
  output logic [7:0]              dec_ddp
);

  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

  // Display symbols beyond the decimal digits 0..9.
  localparam logic [3:0] SYM_F     = 4'hA;
  localparam logic [3:0] SYM_T     = 4'hB;
  localparam logic [3:0] SYM_BLANK = 4'hF;

  state_t      state, state_next;
  logic        accept;
  logic [15:0] bin_q;
  logic [19:0] bcd_q;
  logic [3:0]  iter_q;
  logic [31:0] hold_q;
  logic        mod_q;
  logic [19:0] digits_q;
  logic        mod_disp_q;
  logic        loaded_q;
  logic [19:0] bcd_adj;
  logic [19:0] bcd_shift;
  logic [15:0] bin_shift;
  logic [2:0]  idx_q;
  logic [15:0] refresh_q;
  logic [4:0]  blank;
  logic [3:0]  sym;

  function automatic logic [7:0] seg_code(input logic [3:0] s);
    case (s)
      4'd0:    seg_code = 8'h03;
      4'd1:    seg_code = 8'h9F;
      4'd2:    seg_code = 8'h25;
      4'd3:    seg_code = 8'h0D;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h49;
      4'd6:    seg_code = 8'h41;
      4'd7:    seg_code = 8'h1F;
      4'd8:    seg_code = 8'h01;
      4'd9:    seg_code = 8'h09;
      SYM_F:   seg_code = 8'h71;
      SYM_T:   seg_code = 8'hE1;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic and the pop strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE:    if (rd.data_2_valid && rst) begin
                 accept     = 1'b1;
                 state_next = CONVERT;
               end
      CONVERT: if (iter_q == 4'd15) state_next = HOLD;
      HOLD:    if (hold_q == HOLD_CYCLES - 32'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign rd.data_2_ack = accept;
  assign busy          = (state != IDLE);

  // One double-dabble step: add 3 to each nibble >= 5, then shift left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[18:0], bin_q[15]};
    bin_shift = {bin_q[14:0], 1'b0};
  end

  // Word capture, conversion, hold timing and displayed digit registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      hold_q     <= '0;
      parity     <= 1'b0;
      mod_q      <= 1'b0;
      digits_q   <= '0;
      mod_disp_q <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          bin_q  <= rd.data_2;
          bcd_q  <= '0;
          iter_q <= '0;
          parity <= ^rd.data_2;
          mod_q  <= modules;
        end
        CONVERT: begin
          bin_q  <= bin_shift;
          bcd_q  <= bcd_shift;
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd15) begin
            digits_q   <= bcd_shift;
            mod_disp_q <= mod_q;
            loaded_q   <= 1'b1;
            hold_q     <= '0;
          end
        end
        HOLD: hold_q <= (hold_q == HOLD_CYCLES - 32'd1) ? 32'd0 : hold_q + 32'd1;
        default: ;
      endcase
    end
  end

  // Blank mask for the five numeric digits.
  always_comb begin
    blank = {5{!loaded_q}};
`ifdef DISP_ZERO_BLANK_EN
    begin : zero_blank
      logic lead;
      lead = 1'b1;
      for (int i = 4; i >= 1; i--) begin
        lead = lead && (digits_q[4*i +: 4] == 4'd0);
        if (lead) blank[i] = 1'b1;
      end
    end
`endif
  end

  // Symbol for the digit position currently being scanned.
  always_comb begin
    sym = SYM_BLANK;
    case (idx_q)
      3'd7:    sym = !loaded_q ? SYM_BLANK : (mod_disp_q ? SYM_T : SYM_F);
      3'd6:    sym = {1'b0, prog};
      3'd5:    sym = SYM_BLANK;
      default: sym = blank[idx_q] ? SYM_BLANK : digits_q[4*idx_q +: 4];
    endcase
  end

  // Scan: anode and segments are registered together, index walks 7 -> 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q     <= 3'd7;
      refresh_q <= '0;
      an        <= 8'hFF;
      dec_ddp   <= 8'hFF;
    end else begin
      an      <= ~(8'b1 << idx_q);
      dec_ddp <= seg_code(sym);
      if (refresh_q == REFRESH_DIV - 16'd1) begin
        refresh_q <= '0;
        idx_q     <= idx_q - 3'd1;
      end else begin
        refresh_q <= refresh_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_display_reader.sv
// Self-checking bench for display_reader with REFRESH_DIV=4, HOLD_CYCLES=8.
// A vector table covers single-word conversions; hand-written sequences cover
// reset, scan timing, back-to-back pops, live prog and mid-conversion reset.
module tb_display_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       modules;
  logic [2:0] prog;
  logic       busy;
  logic       parity;
  logic [7:0] an;
  logic [7:0] dec_ddp;

  int n_cmp = 0;
  int n_err = 0;

  display_reader_if rd_bus ();

  display_reader #(
    .REFRESH_DIV (16'd4),
    .HOLD_CYCLES (32'd8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rd      (rd_bus),
    .modules (modules),
    .prog    (prog),
    .busy    (busy),
    .parity  (parity),
    .an      (an),
    .dec_ddp (dec_ddp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     word;
    logic            modules;
    logic [2:0]      prog;
    logic [7:0][7:0] seg;     // seg[7] is the an[7] digit
    logic            parity;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called at a negedge; waits (bounded) for the anode of pos, returns segments.
  task automatic read_digit(input int pos, output logic [7:0] seg_out);
    logic [7:0] want;
    bit found;
    want  = ~(8'h01 << pos);
    found = 0;
    for (int c = 0; c < 64 && !found; c++) begin
      if (an == want) found = 1;
      else @(negedge clk);
    end
    if (!found) check("anode_wait", {56'd0, an}, {56'd0, want});
    seg_out = dec_ddp;
  endtask

  // Called at a negedge after raising valid; returns once ack is seen (before the edge).
  task automatic wait_ack(output bit found);
    found = 0;
    #1;
    for (int c = 0; c < 80 && !found; c++) begin
      if (rd_bus.data_2_ack) found = 1;
      else begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         found;
    logic [7:0] s;
    int         first_ack;
    int         ack_cnt;

    vecs[0] = '{16'd12345, 1'b0, 3'd3, 64'h71_0D_FF_9F_25_0D_99_49, 1'b0};
    vecs[1] = '{16'd65535, 1'b0, 3'd3, 64'h71_0D_FF_41_49_49_0D_49, 1'b0};
    vecs[2] = '{16'd40960, 1'b0, 3'd1, 64'h71_9F_FF_99_03_09_41_03, 1'b0};
`ifdef DISP_ZERO_BLANK_EN
    vecs[3] = '{16'd7,     1'b0, 3'd5, 64'h71_49_FF_FF_FF_FF_FF_1F, 1'b1};
    vecs[4] = '{16'd0,     1'b0, 3'd0, 64'h71_03_FF_FF_FF_FF_FF_03, 1'b0};
    vecs[5] = '{16'd100,   1'b1, 3'd6, 64'hE1_41_FF_FF_FF_9F_03_03, 1'b1};
    vecs[6] = '{16'd42,    1'b1, 3'd7, 64'hE1_1F_FF_FF_FF_FF_99_25, 1'b1};
`else
    vecs[3] = '{16'd7,     1'b0, 3'd5, 64'h71_49_FF_03_03_03_03_1F, 1'b1};
    vecs[4] = '{16'd0,     1'b0, 3'd0, 64'h71_03_FF_03_03_03_03_03, 1'b0};
    vecs[5] = '{16'd100,   1'b1, 3'd6, 64'hE1_41_FF_03_03_9F_03_03, 1'b1};
    vecs[6] = '{16'd42,    1'b1, 3'd7, 64'hE1_1F_FF_03_03_03_99_25, 1'b1};
`endif

    // Reset state, with valid high to confirm no ack leaks out during reset.
    rst                 = 1'b0;
    rd_bus.data_2_valid = 1'b1;
    rd_bus.data_2       = 16'd0;
    modules             = 1'b0;
    prog                = 3'd2;
    repeat (3) @(negedge clk);
    check("rst_an",     {56'd0, an},      64'hFF);
    check("rst_dec",    {56'd0, dec_ddp}, 64'hFF);
    check("rst_busy",   {63'd0, busy},    64'd0);
    check("rst_parity", {63'd0, parity},  64'd0);
    check("rst_ack",    {63'd0, rd_bus.data_2_ack}, 64'd0);

    // Release; scan order and 4-cycle dwell, blank display except prog.
    rd_bus.data_2_valid = 1'b0;
    rst                 = 1'b1;
    for (int k = 0; k < 36; k++) begin
      int         pos;
      logic [7:0] exp_an;
      logic [7:0] exp_dec;
      @(negedge clk);
      pos     = 7 - ((k / 4) % 8);
      exp_an  = ~(8'h01 << pos);
      exp_dec = (pos == 6) ? 8'h25 : 8'hFF;
      check($sformatf("scan_an_%0d", k),  {56'd0, an},      {56'd0, exp_an});
      check($sformatf("scan_dec_%0d", k), {56'd0, dec_ddp}, {56'd0, exp_dec});
    end

    // Table of single-word conversions.
    foreach (vecs[i]) begin
      @(negedge clk);
      rd_bus.data_2       = vecs[i].word;
      modules             = vecs[i].modules;
      prog                = vecs[i].prog;
      rd_bus.data_2_valid = 1'b1;
      wait_ack(found);
      check($sformatf("v%0d_ack", i), {63'd0, found}, 64'd1);
      @(posedge clk);
      #1 rd_bus.data_2_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_parity", i), {63'd0, parity}, {63'd0, vecs[i].parity});
      check($sformatf("v%0d_busy", i),   {63'd0, busy},   64'd1);
      repeat (20) @(negedge clk);
      for (int pos = 7; pos >= 0; pos--) begin
        read_digit(pos, s);
        check($sformatf("v%0d_an%0d", i, pos), {56'd0, s}, {56'd0, vecs[i].seg[pos]});
      end
    end

    // Back-to-back words with valid held high: second ack 25 cycles later.
    @(negedge clk);
    rd_bus.data_2       = 16'd65535;
    modules             = 1'b0;
    rd_bus.data_2_valid = 1'b1;
    wait_ack(found);
    check("b2b_first_ack", {63'd0, found}, 64'd1);
    first_ack = -1;
    for (int k = 1; k <= 40 && first_ack < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rd_bus.data_2 = 16'd7;
        check("b2b_ack_width", {63'd0, rd_bus.data_2_ack}, 64'd0);
        check("b2b_busy_k1",   {63'd0, busy},   64'd1);
        check("b2b_parity1",   {63'd0, parity}, 64'd0);
      end
      if (k == 24) check("b2b_busy_k24", {63'd0, busy}, 64'd1);
      if (rd_bus.data_2_ack) begin
        first_ack = k;
        check("b2b_busy_at_ack", {63'd0, busy}, 64'd0);
      end
    end
    check("b2b_ack_spacing", 64'(first_ack), 64'd25);
    @(posedge clk);
    #1 rd_bus.data_2_valid = 1'b0;
    @(negedge clk);
    check("b2b_parity2", {63'd0, parity}, 64'd1);

    // Source 't' and live prog change during HOLD.
    @(negedge clk);
    rd_bus.data_2       = 16'd100;
    modules             = 1'b1;
    prog                = 3'd3;
    rd_bus.data_2_valid = 1'b1;
    wait_ack(found);
    check("prog_ack", {63'd0, found}, 64'd1);
    @(posedge clk);
    #1 rd_bus.data_2_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("prog_in_hold", {63'd0, busy}, 64'd1);
    prog = 3'd6;
    read_digit(6, s);
    check("prog_live", {56'd0, s}, 64'h41);
    read_digit(7, s);
    check("prog_src_t", {56'd0, s}, 64'hE1);

    // Reset at CONVERT cycle 8 drops the word; no ack until valid in IDLE.
    @(negedge clk);
    rd_bus.data_2       = 16'd7;
    modules             = 1'b0;
    prog                = 3'd4;
    rd_bus.data_2_valid = 1'b1;
    wait_ack(found);
    check("mid_ack", {63'd0, found}, 64'd1);
    repeat (8) @(negedge clk);
    check("mid_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_an",     {56'd0, an},      64'hFF);
    check("mid_dec",    {56'd0, dec_ddp}, 64'hFF);
    check("mid_busy",   {63'd0, busy},    64'd0);
    check("mid_parity", {63'd0, parity},  64'd0);
    check("mid_ack_rst", {63'd0, rd_bus.data_2_ack}, 64'd0);
    rst                 = 1'b1;
    rd_bus.data_2_valid = 1'b0;
    ack_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_bus.data_2_ack || busy) ack_cnt++;
    end
    check("mid_no_ack", 64'(ack_cnt), 64'd0);
    for (int pos = 7; pos >= 0; pos--) begin
      read_digit(pos, s);
      check($sformatf("mid_an%0d", pos), {56'd0, s}, (pos == 6) ? 64'h99 : 64'hFF);
    end
    rd_bus.data_2_valid = 1'b1;
    wait_ack(found);
    check("mid_ack_after", {63'd0, found}, 64'd1);
    @(posedge clk);
    #1 rd_bus.data_2_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
